gate_arbiter: RTL
=================

GATE_ARBITER -- requirements
Module: gate_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters, 2..8.
REQ-002 Parameter HOLD, default 8: maximum consecutive grant cycles per owner, 1..255.
REQ-003 Parameter IDLE_OFF, default 3: request-free IDLE cycles before gate shutdown, 1..15.
REQ-004 Port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-low reset.
REQ-006 Port: req  input  N  per-requester level request; bit i held high while requester i wants the shared gated resource.
REQ-007 Port: done  input  N  per-requester single-cycle release; honoured only for the current owner.
REQ-008 Port: gnt  output  N  registered one-hot grant; all zero when no owner.
REQ-009 Port: gate_en  output  1  registered enable to the gated resource.
REQ-010 Port: owner  output  clog2(N)  registered index of the current or last owner.
REQ-011 Port: busy  output  1  registered; high whenever the FSM is in state GRANT.

Function
REQ-012 FSM states SHALL be OFF, WAKE, GRANT and IDLE, with exactly one state active per cycle.
REQ-013 In OFF: gate_en=0, gnt=0; any req bit high -> WAKE next cycle.
REQ-014 In WAKE: gate_en=1, gnt=0; exactly one cycle, then -> GRANT, giving the resource one enabled cycle before first use.
REQ-015 Winner SHALL be chosen from req sampled in the cycle before GRANT entry, round-robin starting at index (owner+1) mod N.
REQ-016 If req is all zero at WAKE exit, the FSM SHALL go to IDLE instead of GRANT.
REQ-017 In GRANT: gate_en=1, gnt=one-hot(owner), busy=1; hold counter starts at 1 on the entry cycle and increments each cycle.
REQ-018 GRANT ends (-> IDLE next cycle) on the first of: done[owner]=1, req[owner]=0, or hold counter = HOLD.
REQ-019 done bits of non-owners SHALL be ignored.
REQ-020 In IDLE: gate_en=1, gnt=0; at least one cycle, so ownership always changes with a gnt=0 gap.
REQ-021 In IDLE with any req high -> GRANT next cycle with a new round-robin winner; the idle counter clears.
REQ-022 In IDLE with req all zero, the idle counter increments; when it reaches IDLE_OFF -> OFF, gate_en falls on that transition.
REQ-023 On HOLD expiry, an owner still requesting SHALL be re-granted only after all other active requesters are served.
REQ-024 owner SHALL update only on GRANT entry and SHALL keep its value through IDLE, OFF and WAKE.
REQ-025 Counters SHALL saturate, never wrap; the hold counter is 8 bits and the idle counter is 4 bits.

Reset
REQ-026 With reset=0 at a clock edge: state=OFF, gnt=0, gate_en=0, busy=0, owner=N-1 (so index 0 has first priority), both counters=0.
REQ-027 Reset asserted mid-GRANT SHALL drop gnt and gate_en in the same registered update, with no IDLE pass-through.
REQ-028 The first edge after reset release SHALL evaluate req normally from OFF.

Verification
REQ-029 From reset, req=0001 held -> WAKE at cycle 1, gnt=0001 at cycle 2, busy=1, owner=0.
REQ-030 req=1111 held, no done, HOLD=8 -> gnt sequence 0001,0010,0100,1000, each 8 cycles with a single zero cycle between, then wraps to 0001.
REQ-031 Owner 1 pulses done on its 3rd grant cycle while req=0110 -> gnt=0 for one cycle, then gnt=0100.
REQ-032 All req drop during GRANT, IDLE_OFF=3 -> 3 IDLE cycles with gate_en=1, then OFF with gate_en=0.
REQ-033 req rises on the 2nd IDLE cycle -> GRANT next cycle with no WAKE, gate_en stays 1.
REQ-034 reset=0 during GRANT with owner=2 -> next cycle gnt=0, gate_en=0, owner=N-1; done on non-owner is never acted on.

Source files
------------

// File: rtl/gate_arbiter.sv
// gate_arbiter
//   Round-robin arbiter for one shared, clock-gated resource. The gate is
//   woken on demand, handed to one requester at a time with a bounded hold,
//   and shut down again after a run of request-free idle cycles.
//
// Ports
//   clock   : sole clock, rising edge
//   reset   : synchronous, active-low
//   req     : [N-1:0] level requests, bit i high while requester i wants the gate
//   done    : [N-1:0] single-cycle release, only the current owner's bit counts
//   gnt     : [N-1:0] registered one-hot grant, zero when nobody owns the gate
//   gate_en : registered enable to the gated resource
//   owner   : registered index of the current or most recent owner
//   busy    : registered, high while in GRANT
//
// state | meaning
// ------+-------------------------------------------------------------
// OFF   | gate disabled, waiting for any request
// WAKE  | gate enabled for one settling cycle before first use
// GRANT | resource owned by 'owner', hold counter running
// IDLE  | gate enabled, no owner; re-arbitrate or count towards OFF

module gate_arbiter #(
  parameter int N        = 4,
  parameter int HOLD     = 8,
  parameter int IDLE_OFF = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         gnt,
  output logic                 gate_en,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy
);

  localparam int          OW     = $clog2(N);
  localparam logic [7:0]  HOLD_L = 8'(HOLD);
  localparam logic [3:0]  IDLE_L = 4'(IDLE_OFF);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    WAKE  = 2'd1,
    GRANT = 2'd2,
    IDLE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] owner_nxt;
  logic [7:0]    hold_cnt, hold_nxt;
  logic [3:0]    idle_cnt, idle_nxt;
  logic [OW-1:0] winner;
  logic [7:0]    hold_inc;
  logic [3:0]    idle_inc;
  logic          any_req;
  logic          grant_end;

  // Search from owner+1 upward; walking the offsets downward lets the
  // nearest requesting index overwrite any farther one.
  function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r,
                                            input logic [OW-1:0] last);
    logic [OW-1:0] pick;
    int            idx;
    pick = last;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(last) + i) % N;
      if (r[idx]) pick = OW'(idx);
    end
    return pick;
  endfunction

  assign any_req  = |req;
  assign winner   = rr_pick(req, owner);
  assign hold_inc = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
  assign idle_inc = (idle_cnt == 4'hF)  ? idle_cnt : idle_cnt + 4'd1;
  assign grant_end = done[owner] || !req[owner] || (hold_cnt >= HOLD_L);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    hold_nxt  = hold_cnt;
    idle_nxt  = idle_cnt;
    case (state)
      OFF: begin
        hold_nxt = 8'd0;
        idle_nxt = 4'd0;
        if (any_req) state_nxt = WAKE;
      end
      WAKE: begin
        idle_nxt = 4'd0;
        if (any_req) begin
          state_nxt = GRANT;
          owner_nxt = winner;
          hold_nxt  = 8'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (grant_end) begin
          state_nxt = IDLE;
          idle_nxt  = 4'd0;
        end else begin
          hold_nxt = hold_inc;
        end
      end
      IDLE: begin
        if (any_req) begin
          state_nxt = GRANT;
          owner_nxt = winner;
          hold_nxt  = 8'd1;
          idle_nxt  = 4'd0;
        end else begin
          idle_nxt = idle_inc;
          if (idle_inc >= IDLE_L) state_nxt = OFF;
        end
      end
      default: state_nxt = OFF;
    endcase
  end

  // Outputs are registered from the next-state decode so they change on
  // the same edge as the state itself; reset overrides everything, which
  // drops an active grant without passing through IDLE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= OFF;
      owner    <= OW'(N - 1);
      hold_cnt <= 8'd0;
      idle_cnt <= 4'd0;
      gnt      <= '0;
      gate_en  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
      idle_cnt <= idle_nxt;
      gnt      <= (state_nxt == GRANT) ? (N'(1) << owner_nxt) : '0;
      gate_en  <= (state_nxt != OFF);
      busy     <= (state_nxt == GRANT);
    end
  end

endmodule
